// File: rtl/movement_executor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : movement_executor                                             |
// | Function : Executes STOP/FORWARD/TURN opcodes as timed motor drive,      |
// |            tracks heading; optional EXEC_MOVE_CNT_EN adds move_count.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module movement_executor #(
  parameter int FWD_CYCLES  = 8,
  parameter int TURN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] movement_sel,
  input  logic [1:0] state_control,
  output logic       motor_l_en,
  output logic       motor_r_en,
  output logic       motor_l_dir,
  output logic       motor_r_dir,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] heading
`ifdef EXEC_MOVE_CNT_EN
  ,
  output logic [15:0] move_count
`endif
);

  localparam logic [3:0] c_OP_STOP  = 4'd0;
  localparam logic [3:0] c_OP_RIGHT = 4'd1;
  localparam logic [3:0] c_OP_LEFT  = 4'd2;
  localparam logic [3:0] c_OP_FWD   = 4'd4;
  localparam logic [3:0] c_OP_AROUND = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_TURN, S_DONE} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_op;
  logic        r_illegal;
  logic [1:0]  r_heading;

  logic        w_pause;
  logic        w_last;
  logic [15:0] w_base;
  logic [15:0] w_dur;

  assign w_pause = (state_control == 2'b10);
  assign w_last  = !w_pause && (r_cnt == 16'd0);

  // Duration is resolved from the live inputs, so it only matters at the accept edge.
  always_comb begin
    w_base = 16'd1;
    case (movement_sel)
      c_OP_FWD:              w_base = 16'(FWD_CYCLES);
      c_OP_RIGHT, c_OP_LEFT: w_base = 16'(TURN_CYCLES);
      c_OP_AROUND:           w_base = 16'(2 * TURN_CYCLES);
      default:               w_base = 16'd1;
    endcase
    w_dur = (state_control == 2'b01) ? {w_base[14:0], 1'b0} : w_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_op      <= c_OP_STOP;
      r_illegal <= 1'b0;
      r_heading <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op      <= movement_sel;
            r_illegal <= 1'b0;
            case (movement_sel)
              c_OP_FWD: begin
                r_state <= S_FWD;
                r_cnt   <= w_dur - 16'd1;
              end
              c_OP_RIGHT, c_OP_LEFT, c_OP_AROUND: begin
                r_state <= S_TURN;
                r_cnt   <= w_dur - 16'd1;
              end
              c_OP_STOP: r_state <= S_DONE;
              default: begin
                r_state   <= S_DONE;
                r_illegal <= 1'b1;
              end
            endcase
          end
        end
        S_FWD, S_TURN: begin
          if (w_last) begin
            r_state <= S_DONE;
            if (r_state == S_TURN) begin
              case (r_op)
                c_OP_RIGHT:  r_heading <= r_heading + 2'd1;
                c_OP_LEFT:   r_heading <= r_heading - 2'd1;
                c_OP_AROUND: r_heading <= r_heading + 2'd2;
                default:     r_heading <= r_heading;
              endcase
            end
          end else if (!w_pause) begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_illegal <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Motor drive follows the live pause input, not a registered copy of it.
  always_comb begin
    motor_l_en  = 1'b0;
    motor_r_en  = 1'b0;
    motor_l_dir = 1'b0;
    motor_r_dir = 1'b0;
    if (((r_state == S_FWD) || (r_state == S_TURN)) && !w_pause) begin
      motor_l_en = 1'b1;
      motor_r_en = 1'b1;
      case (r_op)
        c_OP_FWD: begin
          motor_l_dir = 1'b1;
          motor_r_dir = 1'b1;
        end
        c_OP_LEFT:  motor_r_dir = 1'b1;
        default:    motor_l_dir = 1'b1;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_DONE) && r_illegal;
  assign heading   = r_heading;

`ifdef EXEC_MOVE_CNT_EN
  logic [15:0] r_move_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_move_cnt <= 16'd0;
    end else if ((r_state == S_FWD) && w_last) begin
      r_move_cnt <= r_move_cnt + 16'd1;
    end
  end

  assign move_count = r_move_cnt;
`else
  // No move counter in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_movement_executor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_movement_executor                                          |
// | Function : Scoreboard bench for movement_executor.                       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_movement_executor;

  localparam int c_FWD  = 8;
  localparam int c_TURN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] movement_sel = 4'd0;
  logic [1:0] state_control = 2'b00;
  logic       motor_l_en, motor_r_en, motor_l_dir, motor_r_dir;
  logic       busy, done, err;
  logic [1:0] heading;
`ifdef EXEC_MOVE_CNT_EN
  logic [15:0] move_count;
`endif

  movement_executor #(
    .FWD_CYCLES  (c_FWD),
    .TURN_CYCLES (c_TURN)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .movement_sel  (movement_sel),
    .state_control (state_control),
    .motor_l_en    (motor_l_en),
    .motor_r_en    (motor_r_en),
    .motor_l_dir   (motor_l_dir),
    .motor_r_dir   (motor_r_dir),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .heading       (heading)
`ifdef EXEC_MOVE_CNT_EN
    ,
    .move_count    (move_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         active;
    int         done_cyc;
    logic       ldir;
    logic       rdir;
    logic       err;
    logic [1:0] hdg;
  } exp_t;

  exp_t       r_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] exp_hdg = 2'b00;
  int         exp_moves = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: accumulates one transaction's motor activity and scores it on done.
  int   mon_cyc = 0;
  int   mon_act = 0;
  int   mon_any = 0;
  logic mon_ldir = 1'b0;
  logic mon_rdir = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_cyc = 0; mon_act = 0; mon_any = 0; mon_ldir = 1'b0; mon_rdir = 1'b0;
    end else if (busy) begin
      mon_cyc++;
      chk("ready_while_busy", {31'd0, cmd_ready}, 32'd0);
      if (done) begin
        if (r_q.size() == 0) begin
          chk("spurious_done", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = r_q.pop_front();
          chk("done_cycle", mon_cyc, e.done_cyc);
          chk("active_both", mon_act, e.active);
          chk("active_any", mon_any, e.active);
          chk("l_dir", {31'd0, mon_ldir}, {31'd0, e.ldir});
          chk("r_dir", {31'd0, mon_rdir}, {31'd0, e.rdir});
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("heading", {30'd0, heading}, {30'd0, e.hdg});
        end
        mon_cyc = 0; mon_act = 0; mon_any = 0; mon_ldir = 1'b0; mon_rdir = 1'b0;
      end else begin
        if (motor_l_en && motor_r_en) mon_act++;
        if (motor_l_en || motor_r_en) begin
          mon_any++;
          mon_ldir = motor_l_dir;
          mon_rdir = motor_r_dir;
        end
        if (state_control == 2'b10)
          chk("pause_motors", {28'd0, motor_l_en, motor_r_en, motor_l_dir, motor_r_dir}, 32'd0);
      end
    end else begin
      chk("idle_outputs", {26'd0, motor_l_en, motor_r_en, motor_l_dir, motor_r_dir, done, err}, 32'd0);
    end
  end

  task automatic do_cmd(input logic [3:0] op, input logic [1:0] mode, input int pst, input int plen);
    exp_t       e;
    int         dur;
    int         n;
    int         k;
    logic [1:0] alt;
    e.ldir = 1'b0; e.rdir = 1'b0; e.err = 1'b0;
    case (op)
      4'd4: begin dur = c_FWD;      e.ldir = 1'b1; e.rdir = 1'b1; exp_moves++; end
      4'd1: begin dur = c_TURN;     e.ldir = 1'b1; exp_hdg = exp_hdg + 2'd1; end
      4'd2: begin dur = c_TURN;     e.rdir = 1'b1; exp_hdg = exp_hdg + 2'd3; end
      4'd8: begin dur = 2 * c_TURN; e.ldir = 1'b1; exp_hdg = exp_hdg + 2'd2; end
      4'd0: dur = 0;
      default: begin dur = 0; e.err = 1'b1; end
    endcase
    if (mode == 2'b01) dur = dur * 2;
    e.active   = dur;
    e.done_cyc = (dur == 0) ? 1 : dur + plen + 1;
    e.hdg      = exp_hdg;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    r_q.push_back(e);
    cmd_valid     = 1'b1;
    movement_sel  = op;
    state_control = mode;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    alt = (mode == 2'b01) ? 2'b00 : 2'b01;
    k = 1;
    while (r_q.size() != 0 && k < 300) begin
      state_control = (plen > 0 && k >= pst && k < pst + plen) ? 2'b10 : alt;
      @(posedge clk); #1;
      k++;
    end
    if (r_q.size() != 0) begin
      chk("done_timeout", r_q.size(), 32'd0);
      r_q.delete();
    end
    state_control = 2'b00;
    chk("ready_after_done", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_heading", {30'd0, heading}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
`ifdef EXEC_MOVE_CNT_EN
    chk("rst_move_count", {16'd0, move_count}, 32'd0);
`endif

    do_cmd(4'd4, 2'b00, 0, 0);   // forward, normal
    do_cmd(4'd2, 2'b01, 0, 0);   // turn left, slow
    do_cmd(4'd4, 2'b00, 4, 3);   // forward with a 3-cycle pause
    do_cmd(4'd3, 2'b00, 0, 0);   // illegal
    do_cmd(4'd0, 2'b00, 0, 0);   // stop
    do_cmd(4'd1, 2'b11, 0, 0);   // turn right, mode 11 acts as normal
    do_cmd(4'd8, 2'b00, 0, 0);   // turn around
    do_cmd(4'd8, 2'b01, 0, 0);   // turn around, slow
    do_cmd(4'd4, 2'b01, 0, 0);   // forward, slow
    do_cmd(4'd1, 2'b00, 2, 2);   // turn right with pause
    do_cmd(4'hF, 2'b01, 0, 0);   // illegal
`ifdef EXEC_MOVE_CNT_EN
    chk("move_count_mid", {16'd0, move_count}, exp_moves);
`endif

    // Reset wins over a simultaneous accept.
    rst = 1'b1; cmd_valid = 1'b1; movement_sel = 4'd4;
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0;
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    exp_hdg = 2'b00; exp_moves = 0;

    // Reset in cycle 3 of a turn-around aborts it.
    do_cmd(4'd1, 2'b00, 0, 0);
    exp_hdg = 2'b00;
    cmd_valid = 1'b1; movement_sel = 4'd8; state_control = 2'b00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_running", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_motors", {28'd0, motor_l_en, motor_r_en, motor_l_dir, motor_r_dir}, 32'd0);
    chk("abort_heading", {30'd0, heading}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    exp_moves = 0;
    repeat (3) @(posedge clk);
    #1;

    do_cmd(4'd4, 2'b00, 0, 0);
    do_cmd(4'd4, 2'b11, 0, 0);
    do_cmd(4'd4, 2'b00, 0, 0);
    do_cmd(4'd1, 2'b00, 0, 0);
    chk("final_heading", {30'd0, heading}, {30'd0, exp_hdg});
`ifdef EXEC_MOVE_CNT_EN
    chk("final_move_count", {16'd0, move_count}, exp_moves);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/movement_executor.md
MOVEMENT_EXECUTOR -- requirements
Module: movement_executor

Interface
REQ-001 Parameter FWD_CYCLES, default 8, SHALL set the active motor cycles for one forward move (legal range 1..32767).
REQ-002 Parameter TURN_CYCLES, default 4, SHALL set the active motor cycles for one 90-degree turn (legal range 1..16383).
REQ-003 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 cmd_valid  in  1  SHALL indicate that a command is offered.
REQ-006 cmd_ready  out  1  SHALL indicate that the executor accepts a command this cycle.
REQ-007 movement_sel  in  4  command opcode: 0 STOP, 1 TURN_RIGHT, 2 TURN_LEFT, 4 FORWARD, 8 TURN_AROUND; all other values are illegal.
REQ-008 state_control  in  2  live mode: 00 normal, 01 slow, 10 pause, 11 treated as normal.
REQ-009 motor_l_en, motor_r_en  out  1 each  motor drive enables.
REQ-010 motor_l_dir, motor_r_dir  out  1 each  direction: 1 forward, 0 reverse.
REQ-011 busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-012 done  out  1  SHALL be a one-cycle completion pulse.
REQ-013 err  out  1  SHALL be a one-cycle pulse, coincident with done, for an illegal opcode.
REQ-014 heading  out  2  tracked orientation: 00 UP, 01 RIGHT, 10 DOWN, 11 LEFT.

Function
REQ-015 The FSM SHALL have states IDLE, FWD, TURN and DONE, with cmd_ready high only in IDLE.
REQ-016 A command SHALL be accepted at a rising edge where cmd_valid and cmd_ready are both high; movement_sel and the slow bit (state_control==01) SHALL be captured at that edge.
REQ-017 On accept, FORWARD SHALL enter FWD and TURN_LEFT/TURN_RIGHT SHALL enter TURN, each loading the down-counter with duration-1.
REQ-018 Duration SHALL be FWD_CYCLES or TURN_CYCLES; TURN_AROUND SHALL use 2*TURN_CYCLES; a captured slow bit SHALL double the duration. The counter SHALL be 16 bits wide.
REQ-019 On accept, STOP and illegal opcodes SHALL go directly to DONE with no motor activity.
REQ-020 In FWD and TURN, the counter SHALL decrement on each cycle where state_control != 10. When the counter is 0 and state_control != 10, the next edge SHALL enter DONE.
REQ-021 In every paused cycle (state_control==10 in FWD or TURN), the counter SHALL hold and all motor outputs SHALL be 0.
REQ-022 Motor outputs SHALL be combinational from state, the captured opcode and the live pause condition, and SHALL be 0 in IDLE and DONE.
REQ-023 Motor drive in unpaused FWD/TURN cycles SHALL be:
- FWD: both enables 1, both dirs 1.
- TURN_RIGHT and TURN_AROUND: enables 1, l_dir 1, r_dir 0.
- TURN_LEFT: enables 1, l_dir 0, r_dir 1.
REQ-024 Heading SHALL update on the edge entering DONE: TURN_RIGHT +1, TURN_LEFT -1, TURN_AROUND +2, all modulo 4. Other opcodes SHALL leave heading unchanged.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE; no command SHALL be accepted in DONE.
REQ-026 A mode change after accept SHALL NOT alter the captured slow bit; only pause SHALL act live.

Reset
REQ-027 When rst is high at an edge, the block SHALL enter IDLE with heading=00, counter=0, done=0, err=0 and busy=0, and all motor outputs SHALL be 0 from the next cycle.
REQ-028 Reset SHALL abort any command in progress, with no done pulse and no heading update.
REQ-029 rst SHALL take priority over a simultaneous command accept.

Configuration
REQ-030 With macro EXEC_MOVE_CNT_EN defined, the block SHALL add output move_count (16 bits, out), which increments on each FWD-to-DONE transition, wraps 65535 to 0, and is reset to 0.
REQ-031 Without EXEC_MOVE_CNT_EN, the move_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 FORWARD accepted at edge 0, mode 00, defaults -> both motors forward in cycles 1..8, done=1 in cycle 9, cmd_ready=1 in cycle 10, heading unchanged.
REQ-033 TURN_LEFT with slow mode at accept, starting from heading 00 -> l_dir=0, r_dir=1 for 8 cycles, then done, heading=11.
REQ-034 FORWARD with state_control=10 for 3 mid-move cycles -> motors 0 during the pause, total active cycles still 8, done in cycle 12.
REQ-035 movement_sel=4'b0011 accepted -> done=1 and err=1 in cycle 1, no motor activity, heading unchanged.
REQ-036 rst asserted in cycle 3 of TURN_AROUND -> IDLE next cycle, motors 0, heading=00, no done pulse.
REQ-037 With EXEC_MOVE_CNT_EN, 3 FORWARD and 1 TURN_RIGHT command -> move_count=3, heading=01.
